sm_display_scan: RTL and testbench
==================================

# sm_display_scan

Time-multiplexed scan controller for the 4-digit common-anode 7-segment module on the GPIO header. It owns the shared segment/anode bus, sequences one digit at a time with inter-digit blanking against ghosting, applies PWM brightness, and captures the displayed value once per frame so digits never tear. It sits at board level between the core's debug/register outputs and the GPIO pins.

## Interface
- `PRESCALE`, 50000: clock cycles per digit slot (1 kHz slot rate at 50 MHz); must be at least `BLANK_CYCLES`+8.
- `BLANK_CYCLES`, 64: cycles at slot start with all anodes off.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; 0 blanks the display and parks the scanner.
- `number`  in  16  four hex digits; [3:0] is digit 0, the rightmost.
- `dp`  in  4  decimal points, active high, bit i → digit i.
- `brightness`  in  3  duty select; on-time fraction is (brightness+1)/8.
- `seven_segments`  out  7  segments g..a, active low.
- `dot`  out  1  decimal point, active low.
- `anodes`  out  4  digit enables, active low, bit i → digit i.
- `frame_done`  out  1  one-cycle pulse at the end of digit 3's slot.

## Operation
- Phase counter `p` runs 0..PRESCALE-1 and wraps. On wrap, digit index `d` advances 0→1→2→3→0.
- Frame capture: on the cycle `p`=0 with `d`=0, latch `number` and `dp` into shadow registers. Every digit in the frame displays the shadow values.
- Per-slot states:
  - BLANK, `p` < BLANK_CYCLES: anodes 4'hF. Segments are loaded with the decode of shadow digit `d`.
  - ON, `p` ≥ BLANK_CYCLES: `anodes[d]`=0 only while `p[2:0]` ≤ `brightness`, otherwise 4'hF. Segments hold.
- Hex decode (g..a, active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- `dot` = ~shadow_dp[d].
- `frame_done` is high for exactly one cycle: the cycle where `d`=3 and `p`=PRESCALE-1.
- `en`=0:
  - Synchronously clears `p` and `d` to 0. Anodes 4'hF, segments 7'h7F, dot 1.
  - No `frame_done` pulse.
  - On the first cycle with `en`=1, the scanner starts at `p`=0, `d`=0 and performs a fresh capture.
- `brightness` and `en` changes take effect on the next cycle. `number` changes take effect only at the next frame capture.
- Reset mid-slot: on the next edge all state returns to reset values, whatever the current phase.

## Timing
- All outputs are registered. Each output reflects the `p`/`d` state of the previous cycle (1-cycle latency).
- Reset values: `anodes`=4'hF, `seven_segments`=7'h7F, `dot`=1, `frame_done`=0. Internal state: `p`=0, `d`=0, shadows 0.
- Slot length is exactly PRESCALE cycles; frame length is 4·PRESCALE cycles.
- Capture happens on the same edge `p` goes 0 for `d`=0. A `number` change on that exact cycle is captured.
- Slot boundary:
  - Previous digit's anode deasserts on the edge where `p` wraps.
  - Next digit's anode asserts no earlier than BLANK_CYCLES cycles later.
  - Two anodes are never low in the same cycle.

## Configuration
- `SM_DISPLAY_LEADING_ZERO_BLANK_EN` defined:
  - During capture, digits above the most significant nonzero digit are flagged blank. Blank digits drive segments 7'h7F, but their decimal point still follows `dp`.
  - Digit 0 is never blanked; `number`=0 shows a single "0".
- Not defined: all four digits are always shown.

## Test plan
Bench parameters: PRESCALE=16, BLANK_CYCLES=4.
- Reset with `en`=1, `number`=16'h12AF, `brightness`=7 → one cycle after reset release `anodes`=4'hF. At `p`=5 of slot 0: `anodes`=4'hE, `seven_segments`=7'h0E. Slots 1/2/3 show 7'h08/7'h24/7'h79 on anodes E→D→B→7 in turn.
- Change `number` from 16'h0000 to 16'h8888 mid-frame, in slot 1 → digits 2 and 3 of this frame still show 7'h40. The next frame shows 7'h00 on all four digits.
- `brightness`=1, observe one slot → anode low on 2 of every 8 ON cycles (`p`[2:0] ∈ {0,1}), 2 cycles per slot total. Never low during BLANK.
- `en` deasserted mid-slot 2, then reasserted → outputs off the cycle after `en`=0. After reassertion the scan restarts at digit 0 with a new capture. `frame_done` fires 64 cycles after restart.
- `dp`=4'b0100 → `dot`=0 only while digit 2 is active. Independently, `frame_done` pulses once every 64 cycles, 1 cycle wide.
- With `SM_DISPLAY_LEADING_ZERO_BLANK_EN` defined, `number`=16'h0050 → digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40. With `number`=0, only digit 0 is lit.

Source files
------------

// File: rtl/sm_display_scan.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional feature: define SM_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zeros.
module sm_display_scan #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] number,
    input  logic [3:0]  dp,
    input  logic [2:0]  brightness,
    output logic [6:0]  seven_segments,
    output logic        dot,
    output logic [3:0]  anodes,
    output logic        frame_done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    // PARK: scanner held at p=0/d=0; BLANK/ON: phase within the current slot
    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [15:0]   shadow_num_q, shadow_num_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [3:0]    shadow_blank_q, shadow_blank_d;
    logic [6:0]    seg_d;
    logic          dot_d;
    logic [3:0]    an_d;
    logic          fd_d;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
    function automatic logic [3:0] lz_blank(input logic [15:0] n);
        logic [3:0] b;
        b[3] = (n[15:12] == 4'h0);
        b[2] = b[3] && (n[11:8] == 4'h0);
        b[1] = b[2] && (n[7:4] == 4'h0);
        b[0] = 1'b0;
        return b;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PARK;
            p_q            <= '0;
            d_q            <= 2'd0;
            shadow_num_q   <= 16'h0000;
            shadow_dp_q    <= 4'h0;
            shadow_blank_q <= 4'h0;
            seven_segments <= 7'h7F;
            dot            <= 1'b1;
            anodes         <= 4'hF;
            frame_done     <= 1'b0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            d_q            <= d_d;
            shadow_num_q   <= shadow_num_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            seven_segments <= seg_d;
            dot            <= dot_d;
            anodes         <= an_d;
            frame_done     <= fd_d;
        end
    end

    // Capture is bypassed into the decode so the capture cycle already sees the new value
    always_comb begin
        state_d        = state_q;
        p_d            = p_q;
        d_d            = d_q;
        shadow_num_d   = shadow_num_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        seg_d          = seven_segments;
        dot_d          = 1'b1;
        an_d           = 4'hF;
        fd_d           = 1'b0;
        nib            = 4'h0;

        if (!en) begin
            state_d = ST_PARK;
            p_d     = '0;
            d_d     = 2'd0;
            seg_d   = 7'h7F;
        end else begin
            if ((p_q == '0) && (d_q == 2'd0)) begin
                shadow_num_d = number;
                shadow_dp_d  = dp;
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
                shadow_blank_d = lz_blank(number);
`else
                shadow_blank_d = 4'h0;
`endif
            end

            if (p_q == P_LAST) begin
                p_d = '0;
                d_d = d_q + 2'd1;
                fd_d = (d_q == 2'd3);
            end else begin
                p_d = p_q + PW'(1);
            end
            state_d = (p_d < P_BLANK) ? ST_BLANK : ST_ON;

            case (d_q)
                2'd0:    nib = shadow_num_d[3:0];
                2'd1:    nib = shadow_num_d[7:4];
                2'd2:    nib = shadow_num_d[11:8];
                default: nib = shadow_num_d[15:12];
            endcase
            dot_d = ~shadow_dp_d[d_q];

            case (state_q)
                ST_PARK, ST_BLANK: begin
                    seg_d = shadow_blank_d[d_q] ? 7'h7F : hex7(nib);
                end
                ST_ON: begin
                    if (p_q[2:0] <= brightness) begin
                        an_d[d_q] = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_PARK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_display_scan.sv
// Self-checking bench for sm_display_scan: time-based reference model plus directed scenarios.
module tb_sm_display_scan;

    localparam int unsigned PRESCALE     = 16;
    localparam int unsigned BLANK_CYCLES = 4;
    localparam int unsigned FRAME        = 4 * PRESCALE;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] number;
    logic [3:0]  dp;
    logic [2:0]  brightness;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [3:0]  anodes;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model: t = cycles since scanning (re)started, i.e. position in the frame
    int          t = 0;
    logic [15:0] cap_num = 16'h0;
    logic [3:0]  cap_dp = 4'h0;
    logic [6:0]  e_seg;
    logic        e_dot;
    logic [3:0]  e_an;
    logic        e_fd;
    int          lows;
    int          fds;

    sm_display_scan #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .number         (number),
        .dp             (dp),
        .brightness     (brightness),
        .seven_segments (seven_segments),
        .dot            (dot),
        .anodes         (anodes),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    function automatic bit digit_blank(input logic [15:0] n, input int dg);
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
        return (dg != 0) && ((n >> (4 * dg)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Predict the outputs registered at the coming edge, advance one cycle, compare
    task automatic step();
        int p;
        int dg;
        int nb;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dot = 1'b1; e_fd = 1'b0;
            t = 0; cap_num = 16'h0; cap_dp = 4'h0;
        end else if (!en) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dot = 1'b1; e_fd = 1'b0;
            t = 0;
        end else begin
            p  = t % PRESCALE;
            dg = t / PRESCALE;
            if (t == 0) begin
                cap_num = number;
                cap_dp  = dp;
            end
            nb    = (cap_num >> (4 * dg)) & 16'hF;
            e_seg = digit_blank(cap_num, dg) ? 7'h7F : HEX_TAB[nb];
            e_dot = ~cap_dp[dg];
            e_an  = ((p >= BLANK_CYCLES) && ((p % 8) <= brightness))
                    ? (4'hF ^ 4'(1 << dg)) : 4'hF;
            e_fd  = (t == FRAME - 1);
            t     = (t + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        check("anodes", anodes, e_an);
        check("segments", seven_segments, e_seg);
        check("dot", dot, e_dot);
        check("frame_done", frame_done, e_fd);
        if (anodes != 4'hF) lows++;
        if (frame_done) fds++;
    endtask

    // Step until the model's next position is tt (outputs then reflect position tt-1)
    task automatic run_to(input int tt);
        for (int i = 0; i < 4 * FRAME && t != tt; i++) step();
        check("run_to_reached", t, tt);
    endtask

    logic [6:0] exp_lz [4];
    int n;

    initial begin
        rst = 1'b1; en = 1'b1; number = 16'h12AF; dp = 4'h0; brightness = 3'd7;
        repeat (3) step();

        // Power-up frame: F, A, 2, 1 on anodes E, D, B, 7
        rst = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == 0) check("release_anodes_off", anodes, 4'hF);
            if (i == 5) begin
                check("slot0_p5_anodes", anodes, 4'hE);
                check("slot0_p5_seg", seven_segments, 7'h0E);
            end
            if (i == 16 + 5) check("slot1_seg", seven_segments, 7'h08);
            if (i == 32 + 5) check("slot2_anodes", anodes, 4'hB);
            if (i == 48 + 5) begin
                check("slot3_anodes", anodes, 4'h7);
                check("slot3_seg", seven_segments, 7'h79);
            end
        end

        // Mid-frame number change does not tear the frame
        number = 16'h0000;
        run_to(0);
        step();
        run_to(19);
        number = 16'h8888;
        run_to(41);
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
        check("no_tear_slot2", seven_segments, 7'h7F);
`else
        check("no_tear_slot2", seven_segments, 7'h40);
`endif
        run_to(0);
        run_to(41);
        check("new_frame_slot2", seven_segments, 7'h00);

        // Brightness 1: two ON cycles per slot
        brightness = 3'd1;
        lows = 0;
        repeat (FRAME) step();
        check("bright1_low_cycles", lows, 8);
        brightness = 3'd7;

        // Enable drop mid-slot 2, restart gives a fresh frame
        run_to(37);
        en = 1'b0;
        step();
        check("en_off_anodes", anodes, 4'hF);
        repeat (5) step();
        number = 16'h3C5E;
        en = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < 200);
        check("restart_fd_latency", n, FRAME);

        // Decimal point on digit 2; frame_done cadence
        dp = 4'b0100;
        fds = 0;
        repeat (4 * FRAME) begin
            number = 16'($urandom);
            step();
        end
        check("fd_pulses_256", fds, 4);

        // Leading-zero behaviour (plain decode when the feature is off)
        number = 16'h0050;
        dp = 4'h0;
        run_to(0);
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
        exp_lz = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
        exp_lz = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
        for (int s = 0; s < 4; s++) begin
            run_to(s * PRESCALE + 9);
            check("lz_digit", seven_segments, exp_lz[s]);
        end
        number = 16'h0000;
        run_to(0);
        lows = 0;
        repeat (FRAME) step();
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
        run_to(41);
        check("zero_digit2_blank", seven_segments, 7'h7F);
`else
        run_to(41);
        check("zero_digit2_shown", seven_segments, 7'h40);
`endif

        // Reset mid-slot
        run_to(23);
        rst = 1'b1;
        step();
        check("midslot_rst_anodes", anodes, 4'hF);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            number = 16'($urandom);
            dp     = 4'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
            if ($urandom_range(0, 79) == 0) en = ~en;
            if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
